instruction_fetch: RTL

Fetch stage of the pipelined CPU: owns the program counter, drives the word address into the instruction memory, captures the combinationally returned instruction word, and presents it to decode through the IF/ID pipeline register. It is the initiator side of the instruction-memory read interface. It also handles hazard stalls and branch redirects (with flush) from later stages, and keeps a fetched-instruction counter.

---
 rtl/instruction_fetch.sv | 73 +++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads instruction memory combinationally, and loads the IF/ID register.
// Latency: the instruction at imem_addr lands in IF/ID on the edge that ends that cycle (1 cycle).
// Backpressure: stall holds PC/IF/ID/count; branch_taken redirects and flushes IF/ID, even while stalled.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_q;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_pc;
    logic        advance;

    // Target low bits are forced to zero so the PC stays word-aligned.
    logic        unused_tgt_lsbs;
    assign unused_tgt_lsbs = ^branch_target[1:0];

    assign redirect_pc = {branch_target[31:2], 2'b00};
    assign pc_plus4    = pc_q + 32'd4;
    // A normal fetch happens only when nothing of higher priority claims the edge.
    assign advance     = !branch_taken && !stall;

    // The memory sees the PC register directly, with no logic in between.
    assign imem_addr = pc_q;

    // Program counter: reset > redirect > stall (hold) > sequential advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else if (branch_taken) begin
            pc_q <= redirect_pc;
        end else if (!stall) begin
            pc_q <= pc_plus4;
        end
    end

    // IF/ID register: flushed to a nop on reset or redirect, held on stall, loaded otherwise.
    always_ff @(posedge clk) begin
        if (reset || branch_taken) begin
            if_id_pc       <= 32'h0;
            if_id_pc_plus4 <= 32'h0;
            if_id_instr    <= 32'h0;
            if_id_valid    <= 1'b0;
        end else if (advance) begin
            if_id_pc       <= pc_q;
            if_id_pc_plus4 <= pc_plus4;
            if_id_instr    <= imem_data;
            if_id_valid    <= 1'b1;
        end
    end

    // Count every instruction latched as valid; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= 32'h0;
        end else if (advance) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule
